// File: rtl/axil_spi_bridge_if.sv
// -----------------------------------------------------------------------------
// axil_spi_bridge_if
// AXI4-Lite bus bundle between a bus master and the axil_spi_bridge slave.
//   s_aw*  : write address channel (addr, valid, ready)
//   s_w*   : write data channel    (data, strb, valid, ready)
//   s_b*   : write response        (resp, valid, ready)
//   s_ar*  : read address channel  (addr, valid, ready)
//   s_r*   : read data/response    (data, resp, valid, ready)
// Modports: slave (bridge side), master (initiator side).
// -----------------------------------------------------------------------------
interface axil_spi_bridge_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axil_spi_bridge.sv
// -----------------------------------------------------------------------------
// axil_spi_bridge
// AXI4-Lite slave that turns each bus access into one SPI register transaction
// on a downstream SPI master engine. Writes send wdata[7:0] to register
// addr[5:2] of device addr[7:6]; reads return the engine's byte on rdata[7:0].
// A request that sees no spi_ready within TIMEOUT_CYCLES is aborted with
// SLVERR and followed by GUARD_CYCLES idle cycles so the engine can drain.
// Ports:
//   iclk, irstn : clock, synchronous active-low reset
//   s_axil      : AXI4-Lite slave bundle (axil_spi_bridge_if.slave)
//   spi_wr_en   : held high while an SPI write is requested
//   spi_rd_en   : held high while an SPI read is requested
//   spi_addr    : SPI register address
//   spi_wdata   : SPI write byte
//   spi_dev     : device / chip-select index
//   spi_ready   : engine done (high while request still asserted)
//   spi_rdata   : read byte, valid while spi_ready=1
// -----------------------------------------------------------------------------
module axil_spi_bridge #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GUARD_CYCLES   = 24
) (
  input  logic                    iclk,
  input  logic                    irstn,
  axil_spi_bridge_if.slave        s_axil,
  output logic                    spi_wr_en,
  output logic                    spi_rd_en,
  output logic [3:0]              spi_addr,
  output logic [7:0]              spi_wdata,
  output logic [1:0]              spi_dev,
  input  logic                    spi_ready,
  input  logic [7:0]              spi_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_RD_REQ, S_DRAIN, S_GUARD, S_BRESP, S_RRESP
  } state_e;

  state_e            r_state;
  state_e            w_next;

  logic              r_aw_full;
  logic [5:0]        r_aw_addr;   // only addr[7:2] is decoded
  logic              r_w_full;
  logic [7:0]        r_w_byte;
  logic              r_w_strb0;
  logic              r_is_rd;
  logic [15:0]       r_cnt;
  logic [3:0]        r_spi_addr;
  logic [7:0]        r_spi_wdata;
  logic [1:0]        r_spi_dev;
  logic [31:0]       r_rdata;
  logic [1:0]        r_bresp;
  logic [1:0]        r_rresp;

  logic              w_awready;
  logic              w_wready;
  logic              w_arready;
  logic              w_bvalid;
  logic              w_rvalid;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_ar_hs;
  logic              w_timeout;
  logic              w_guard_done;
  logic              w_counting;
  logic              w_unused;

  assign w_aw_hs      = s_axil.s_awvalid && w_awready;
  assign w_w_hs       = s_axil.s_wvalid  && w_wready;
  assign w_ar_hs      = s_axil.s_arvalid && w_arready;
  assign w_timeout    = (r_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign w_guard_done = (r_cnt == 16'(GUARD_CYCLES - 1));
  assign w_counting   = (r_state == S_WR_REQ) || (r_state == S_RD_REQ) ||
                        (r_state == S_GUARD);

  assign w_unused = ^{s_axil.s_awaddr[1:0], s_axil.s_araddr[1:0],
                      s_axil.s_wdata[31:8], s_axil.s_wstrb[3:1]};

  // State register
  always_ff @(posedge iclk) begin
    if (!irstn) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a fully latched write wins over a pending read
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_aw_full && r_w_full) w_next = r_w_strb0 ? S_WR_REQ : S_BRESP;
        else if (w_ar_hs)          w_next = S_RD_REQ;
      end
      S_WR_REQ, S_RD_REQ: begin
        if (spi_ready)      w_next = S_DRAIN;
        else if (w_timeout) w_next = S_GUARD;
      end
      S_DRAIN: if (!spi_ready)   w_next = r_is_rd ? S_RRESP : S_BRESP;
      S_GUARD: if (w_guard_done) w_next = r_is_rd ? S_RRESP : S_BRESP;
      S_BRESP: if (s_axil.s_bready) w_next = S_IDLE;
      S_RRESP: if (s_axil.s_rready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state. Readies are also held low while irstn is
  // asserted, since IDLE with empty latches would otherwise advertise ready.
  always_comb begin
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_arready = 1'b0;
    if (irstn && (r_state == S_IDLE)) begin
      w_awready = !r_aw_full;
      w_wready  = !r_w_full;
      w_arready = !r_aw_full && !r_w_full;
    end
    w_bvalid = (r_state == S_BRESP);
    w_rvalid = (r_state == S_RRESP);
    w_wr_en  = (r_state == S_WR_REQ);
    w_rd_en  = (r_state == S_RD_REQ);
  end

  // Datapath: AW/W holding latches, timeout/guard counter, SPI fields, responses
  always_ff @(posedge iclk) begin
    if (!irstn) begin
      r_aw_full   <= 1'b0;
      r_aw_addr   <= '0;
      r_w_full    <= 1'b0;
      r_w_byte    <= '0;
      r_w_strb0   <= 1'b0;
      r_is_rd     <= 1'b0;
      r_cnt       <= '0;
      r_spi_addr  <= '0;
      r_spi_wdata <= '0;
      r_spi_dev   <= '0;
      r_rdata     <= '0;
      r_bresp     <= '0;
      r_rresp     <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= s_axil.s_awaddr[7:2];
      end
      if (w_w_hs) begin
        r_w_full  <= 1'b1;
        r_w_byte  <= s_axil.s_wdata[7:0];
        r_w_strb0 <= s_axil.s_wstrb[0];
      end
      if ((r_state == S_BRESP) && s_axil.s_bready) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end

      // One counter serves both the request timeout and the guard interval;
      // it restarts from zero on every state change.
      if (w_counting && (w_next == r_state)) r_cnt <= r_cnt + 16'd1;
      else                                   r_cnt <= '0;

      case (r_state)
        S_IDLE: begin
          if (r_aw_full && r_w_full) begin
            r_is_rd <= 1'b0;
            if (r_w_strb0) begin
              r_spi_addr  <= r_aw_addr[3:0];
              r_spi_dev   <= r_aw_addr[5:4];
              r_spi_wdata <= r_w_byte;
            end else begin
              r_bresp <= 2'b10;
            end
          end else if (w_ar_hs) begin
            r_is_rd    <= 1'b1;
            r_spi_addr <= s_axil.s_araddr[5:2];
            r_spi_dev  <= s_axil.s_araddr[7:6];
          end
        end
        S_WR_REQ: begin
          if (spi_ready)      r_bresp <= 2'b00;
          else if (w_timeout) r_bresp <= 2'b10;
        end
        S_RD_REQ: begin
          if (spi_ready) begin
            r_rdata <= {24'h0, spi_rdata};
            r_rresp <= 2'b00;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_rresp <= 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axil.s_awready = w_awready;
  assign s_axil.s_wready  = w_wready;
  assign s_axil.s_arready = w_arready;
  assign s_axil.s_bvalid  = w_bvalid;
  assign s_axil.s_bresp   = r_bresp;
  assign s_axil.s_rvalid  = w_rvalid;
  assign s_axil.s_rdata   = r_rdata;
  assign s_axil.s_rresp   = r_rresp;

  assign spi_wr_en = w_wr_en;
  assign spi_rd_en = w_rd_en;
  assign spi_addr  = r_spi_addr;
  assign spi_wdata = r_spi_wdata;
  assign spi_dev   = r_spi_dev;

endmodule
